// File: rtl/fifo_reader_pkg.sv
// Shared sizing and state encoding for the FIFO drain block (fifo_reader).
// Optional rd_cnt_o delivery counter is enabled with FIFO_READER_CNT_EN.
package fifo_reader_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PEND_W    = OCC_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Words the reader already owns: buffered ones plus the read returning now.
  function automatic logic [PEND_W-1:0] pending_words(input logic [OCC_W-1:0] occ,
                                                      input logic             inflight);
    return {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer; entry 0 is always the oldest word.
module fifo_reader_skid
  import fifo_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [OCC_W-1:0]  occ_o
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              pop_s;

  // Next entry contents and occupancy for every write/pop combination
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    pop_s  = pop_i && (occ_q != OCC_W'(0));
    case ({wr_i, pop_s})
      2'b10: begin
        case (occ_q)
          OCC_W'(0): begin
            ent0_d = wdata_i;
            occ_d  = OCC_W'(1);
          end
          OCC_W'(1): begin
            ent1_d = wdata_i;
            occ_d  = OCC_W'(2);
          end
          default: begin
            occ_d = occ_q;
          end
        endcase
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - OCC_W'(1);
      end
      2'b11: begin
        // Full buffer shifts and refills in one cycle, so occupancy holds.
        if (occ_q == OCC_W'(1)) begin
          ent0_d = wdata_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = wdata_i;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Buffer storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= {DATA_W{1'b0}};
      ent1_q <= {DATA_W{1'b0}};
      occ_q  <= OCC_W'(0);
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign valid_o = (occ_q != OCC_W'(0));
  assign data_o  = ent0_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency SyncFIFO into a valid/ready stream via a 2-entry buffer.
// Define FIFO_READER_CNT_EN to add the rd_cnt_o delivered-word counter.
module fifo_reader
  import fifo_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic              fifo_re_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_empty_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              busy_o
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [DATA_W-1:0] rd_cnt_o
`endif
);

  state_e            state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [OCC_W-1:0]  occ_s;
  logic [PEND_W-1:0] pend_s;
  logic              pop_s;
  logic              room_s;

  assign pop_s  = m_valid_o && m_ready_i;
  assign pend_s = pending_words(occ_s, inflight_q);
  // A read may go out only if its word is guaranteed a slot when it returns.
  assign room_s = (pend_s - {{OCC_W{1'b0}}, pop_s}) < PEND_W'(BUF_DEPTH);

  // State register and read-in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state logic; a read issued this cycle keeps RUN from skipping FLUSH
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_RUN;
        else      state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (en_i)                                        state_d = ST_RUN;
        else if ((pend_s != PEND_W'(0)) || fifo_re_o)    state_d = ST_FLUSH;
        else                                             state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (en_i)                         state_d = ST_RUN;
        else if (pend_s == PEND_W'(0))    state_d = ST_IDLE;
        else                              state_d = ST_FLUSH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: read strobe, busy flag and next in-flight flag
  always_comb begin
    fifo_re_o = 1'b0;
    busy_o    = 1'b0;
    if (state_q == ST_RUN) begin
      fifo_re_o = !fifo_empty_i && room_s;
    end else begin
      fifo_re_o = 1'b0;
    end
    busy_o     = (state_q != ST_IDLE);
    inflight_d = fifo_re_o;
  end

  fifo_reader_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (inflight_q),
    .wdata_i (fifo_data_i),
    .pop_i   (pop_s),
    .valid_o (m_valid_o),
    .data_o  (m_data_o),
    .occ_o   (occ_s)
  );

`ifdef FIFO_READER_CNT_EN
  logic [DATA_W-1:0] cnt_q, cnt_d;

  // Delivered-word count, wraps naturally at the top of its range
  always_comb begin
    if (pop_s) cnt_d = cnt_q + DATA_W'(1);
    else       cnt_d = cnt_q;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {DATA_W{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign rd_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: behavioural SyncFIFO source, expected-word queue.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en_i, m_ready_i;
  logic        fifo_re_o, fifo_empty_i, m_valid_o, busy_o;
  logic [31:0] fifo_data_i, m_data_o;
`ifdef FIFO_READER_CNT_EN
  logic [31:0] rd_cnt_o;
`endif

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [31:0] fmem[0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          reads_seen = 0;
  logic        fifo_clr = 1'b0;

  fifo_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .fifo_re_o    (fifo_re_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .busy_o       (busy_o)
`ifdef FIFO_READER_CNT_EN
    ,
    .rd_cnt_o     (rd_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // SyncFIFO model: one-cycle read latency, junk on the data bus otherwise
  assign fifo_empty_i = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_re_o && !fifo_empty_i) begin
      fifo_data_i <= fmem[rd_ptr[5:0]];
      rd_ptr      <= rd_ptr + 1;
    end else begin
      fifo_data_i <= $urandom;
    end
    if (fifo_re_o) reads_seen <= reads_seen + 1;
  end

  task automatic push_word(input logic [31:0] w, input bit expect_out);
    fmem[wr_ptr[5:0]] = w;
    wr_ptr++;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en_i = 1'b0; m_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid_o !== 1'b0 || m_data_o !== 32'h0 || busy_o !== 1'b0 || fifo_re_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b re=%b, required all 0",
               m_valid_o, m_data_o, busy_o, fifo_re_o);
    end
    tests_run++;
    if (dut.state_q !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required %0d", dut.state_q, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int first_k, last_k, pops, gaps;
    first_k = -1; last_k = -1; pops = 0; gaps = 0;
    for (int i = 1; i <= 4; i++) push_word(32'(i), 1'b1);
    m_ready_i = 1'b1;
    en_i      = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_valid_o && m_ready_i) begin
        if (first_k < 0) first_k = k;
        if (last_k >= 0 && k != last_k + 1) gaps++;
        last_k = k;
        pops++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_extra: got %h, required no word", m_data_o);
        end else begin
          exp_w = exp_q.pop_front();
          if (m_data_o !== exp_w) begin
            tests_failed++;
            $display("FAIL stream_data: got %h, required %h", m_data_o, exp_w);
          end
        end
      end
    end
    tests_run++;
    if (first_k !== 3) begin
      tests_failed++;
      $display("FAIL stream_latency: first word after edge %0d, required 3", first_k);
    end
    tests_run++;
    if (pops !== 4 || gaps !== 0) begin
      tests_failed++;
      $display("FAIL stream_rate: %0d words with %0d gaps, required 4 words 0 gaps", pops, gaps);
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_idle: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = reads_seen;
    m_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) push_word(32'(i), 1'b1);
    en_i = 1'b1;
    repeat (8) @(negedge clk);
    tests_run++;
    if (reads_seen - base !== 2) begin
      tests_failed++;
      $display("FAIL bp_reads: got %0d reads, required 2", reads_seen - base);
    end
    tests_run++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h1) begin
      tests_failed++;
      $display("FAIL bp_hold: valid=%b data=%h, required 1 / 00000001", m_valid_o, m_data_o);
    end
    m_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (m_valid_o && m_ready_i) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_extra: got %h, required no word", m_data_o);
        end else begin
          exp_w = exp_q.pop_front();
          if (m_data_o !== exp_w) begin
            tests_failed++;
            $display("FAIL bp_data: got %h, required %h", m_data_o, exp_w);
          end
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL bp_drain: %0d words missing, required 0", exp_q.size());
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush();
    int base;
    base = reads_seen;
    m_ready_i = 1'b1;
    push_word(32'hA1, 1'b1);
    push_word(32'hA2, 1'b1);
    push_word(32'hA3, 1'b0);
    en_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tests_run++;
        if (dut.state_q !== ST_FLUSH || busy_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL flush_enter: state=%0d busy=%b, required %0d / 1", dut.state_q, busy_o, ST_FLUSH);
        end
      end
      if (m_valid_o && m_ready_i) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL flush_extra: got %h, required no word", m_data_o);
        end else begin
          exp_w = exp_q.pop_front();
          if (m_data_o !== exp_w) begin
            tests_failed++;
            $display("FAIL flush_data: got %h, required %h", m_data_o, exp_w);
          end
        end
      end
    end
    tests_run++;
    if (busy_o !== 1'b0 || dut.state_q !== ST_IDLE || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL flush_exit: busy=%b state=%0d pending=%0d, required 0 / %0d / 0",
               busy_o, dut.state_q, exp_q.size(), ST_IDLE);
    end
    tests_run++;
    if (reads_seen - base !== 2) begin
      tests_failed++;
      $display("FAIL flush_reads: got %0d reads, required 2", reads_seen - base);
    end
    clear_fifo();
  endtask

  task automatic test_empty();
    int re_seen;
    re_seen = 0;
    en_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (fifo_re_o) re_seen++;
    end
    tests_run++;
    if (re_seen !== 0 || m_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_run: re_cycles=%0d valid=%b busy=%b, required 0 / 0 / 1", re_seen, m_valid_o, busy_o);
    end
    en_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'hB0 + 32'(i), 1'b0);
    en_i = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (dut.u_skid.occ_q !== 2'd2) begin
      tests_failed++;
      $display("FAIL rstmid_fill: occ=%0d, required 2", dut.u_skid.occ_q);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid_o !== 1'b0 || m_data_o !== 32'h0 || busy_o !== 1'b0 || fifo_re_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: valid=%b data=%h busy=%b re=%b, required all 0",
               m_valid_o, m_data_o, busy_o, fifo_re_o);
    end
    en_i = 1'b0;
    clear_fifo();
    rst_n     = 1'b1;
    m_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid_o) stale++;
    end
    tests_run++;
    if (stale !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_stale: %0d valid cycles after release, required 0", stale);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 12; i++) push_word($urandom, 1'b1);
    en_i = 1'b1;
    cyc  = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      m_ready_i = 1'($urandom_range(0, 1));
      if (m_valid_o && m_ready_i) begin
        tests_run++;
        exp_w = exp_q.pop_front();
        if (m_data_o !== exp_w) begin
          tests_failed++;
          $display("FAIL b2b_data: got %h, required %h", m_data_o, exp_w);
        end
      end
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_timeout: %0d words undelivered, required 0", exp_q.size());
    end
    en_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_extra: valid=%b busy=%b after drain, required 0 / 0", m_valid_o, busy_o);
    end
  endtask

`ifdef FIFO_READER_CNT_EN
  task automatic test_count_wrap();
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    for (int i = 0; i < 5; i++) push_word(32'hC0 + 32'(i), 1'b1);
    m_ready_i = 1'b1;
    en_i      = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_valid_o && m_ready_i && exp_q.size() != 0) begin
        tests_run++;
        exp_w = exp_q.pop_front();
        if (m_data_o !== exp_w) begin
          tests_failed++;
          $display("FAIL cnt_data: got %h, required %h", m_data_o, exp_w);
        end
      end
    end
    tests_run++;
    if (rd_cnt_o !== 32'h3) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got %h, required 00000003", rd_cnt_o);
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty();
    test_reset_mid();
    test_back_to_back();
`ifdef FIFO_READER_CNT_EN
    test_count_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have exactly one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  async active-low reset.
REQ-004 SHALL have port: en_i  input  1  drain enable.
REQ-005 SHALL have port: fifo_re_o  output  1  read strobe to SyncFIFO re_i.
REQ-006 SHALL have port: fifo_data_i  input  32  SyncFIFO data_o.
REQ-007 SHALL have port: fifo_empty_i  input  1  SyncFIFO empty_o.
REQ-008 SHALL have port: m_valid_o  output  1  output stream word valid.
REQ-009 SHALL have port: m_ready_i  input  1  downstream accept.
REQ-010 SHALL have port: m_data_o  output  32  output stream word.
REQ-011 SHALL have port: busy_o  output  1  high in RUN or FLUSH.
REQ-012 SHALL have port (only with FIFO_READER_CNT_EN): rd_cnt_o  output  32  words delivered downstream.

Function
REQ-013 SHALL treat FIFO read latency as 1 cycle: fifo_data_i sampled the cycle after fifo_re_o was high.
REQ-014 SHALL hold read words in a 2-entry output buffer; m_data_o = oldest entry; m_valid_o = buffer non-empty.
REQ-015 SHALL pop on m_valid_o && m_ready_i; m_data_o/m_valid_o stable while m_valid_o && !m_ready_i.
REQ-016 SHALL assert fifo_re_o only when state==RUN && !fifo_empty_i && (occ + inflight - pop) < 2; occ 0..2, inflight 0..1.
REQ-017 SHALL sustain 1 word/cycle when FIFO non-empty and m_ready_i held high; first word m_valid_o 2 cycles after en_i rises with FIFO non-empty.
REQ-018 SHALL never overflow buffer: simultaneous write-in (returned read) and pop at occ=2 keeps occ=2, order preserved.
REQ-019 SHALL implement FSM IDLE/RUN/FLUSH: IDLE->RUN on en_i; RUN->FLUSH on !en_i with occ+inflight>0; RUN->IDLE on !en_i with occ+inflight==0; FLUSH->IDLE when occ+inflight==0; FLUSH->RUN on en_i.
REQ-020 SHALL issue no reads in IDLE/FLUSH; FLUSH still delivers buffered and in-flight words.
REQ-021 SHALL ignore fifo_data_i when no read in flight.

Reset
REQ-022 SHALL on rst_n low immediately: state IDLE, fifo_re_o=0, m_valid_o=0, m_data_o=0, busy_o=0, occ=0, inflight=0, rd_cnt_o=0.
REQ-023 SHALL discard buffered/in-flight words on reset mid-operation; no word emitted after reset release until a new read completes.

Configuration
REQ-024 SHALL, with FIFO_READER_CNT_EN defined, provide rd_cnt_o incrementing by 1 per pop, wrapping 0xFFFFFFFF->0.
REQ-025 SHALL, without FIFO_READER_CNT_EN, omit rd_cnt_o port and counter logic; other behaviour identical.

Structure
REQ-026 SHALL place FSM state enum, data width (32) and buffer depth (2) in package fifo_reader_pkg.
REQ-027 SHALL implement the 2-entry buffer as sub-module fifo_reader_skid; FSM and read issue in fifo_reader.

Verification
REQ-028 SHALL cover: FIFO preloaded 0x1..0x4, en_i=1, m_ready_i=1 -> m_data_o 0x1,0x2,0x3,0x4 on consecutive cycles, first at en_i+2.
REQ-029 SHALL cover: 3 words, m_ready_i=0 -> exactly 2 reads issued, m_data_o held 0x1; m_ready_i=1 -> 0x1,0x2,0x3 in order.
REQ-030 SHALL cover: en_i dropped the cycle after a read -> state FLUSH, word delivered, then IDLE, busy_o=0, no further fifo_re_o.
REQ-031 SHALL cover: FIFO empty with en_i=1 -> fifo_re_o stays 0, m_valid_o 0, busy_o 1.
REQ-032 SHALL cover: rst_n low while occ=2 -> all outputs 0 same cycle; after release no stale word.
REQ-033 SHALL cover (CNT_EN): 5 pops from rd_cnt_o=0xFFFFFFFE -> rd_cnt_o=0x3.
